// File: rtl/pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// pll_sup_pkg
//   Shared types and helpers for the PLL lock supervisor.
//   - state_e : supervisor FSM states
//   - cnt_w   : width of the shared cycle counter for a given largest count
//   - max_of  : integer maximum, used to size the counter from the parameters
// ---------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,   // PLL held in reset
        S_WAIT,     // PLL released, waiting for first lock
        S_STABLE,   // lock seen, qualifying it for a run of consecutive cycles
        S_RELEASE,  // lock qualified, system reset still held
        S_RUN       // system running on the PLL clock
    } state_e;

    // One bit of headroom above clog2 so that a count equal to a power of two
    // is still representable.
    function automatic int cnt_w(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for one asynchronous level into the refclk domain.
//   Output lags the input by two refclk edges.
//   Ports:
//     refclk  in   reference clock
//     rst     in   synchronous active-high reset; both stages clear to 0
//     d       in   asynchronous input level
//     q       out  synchronised level
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its source; with = the two stages would collapse
    // into one and the second flop would see the freshly written first.
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//   Controls the PLL reset, qualifies the synchronised 'locked' signal, retries
//   on lock timeout and releases a registered system reset / ready flag once
//   lock has been stable long enough. Loss of lock while running re-resets the
//   PLL. All outputs are registered from the next-state decode so they change
//   on the same edge as the state they belong to.
//   Ports:
//     refclk       in   50 MHz reference clock (sole clock)
//     rst          in   synchronous active-high reset
//     pll_locked   in   PLL 'locked', asynchronous
//     pll_rst      out  reset to the PLL
//     sys_rst      out  downstream system reset, active high
//     pll_ready    out  high only in S_RUN
//     lock_lost    out  one-cycle pulse on loss of lock in S_RUN
//     retry_count  out  timeouts plus run-time lock losses, saturating
// ---------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 50,
    parameter int LOCK_STABLE_CYCLES  = 5000,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int SYS_RST_HOLD_CYCLES = 16,
    parameter int RETRY_W             = 8
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               pll_ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                    max_of(LOCK_TIMEOUT_CYCLES, SYS_RST_HOLD_CYCLES));
    localparam int CNT_W   = cnt_w(CNT_MAX);

    // The counter reads N-1 during the N-th cycle in a state, so comparing
    // against N-1 moves the FSM exactly N edges after it entered the state.
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SYS_RST_HOLD_CYCLES - 1);

    logic lock_s;

    sync_2ff u_lock_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (pll_locked),
        .q      (lock_s)
    );

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic               pll_rst_q,   pll_rst_d;
    logic               sys_rst_q,   sys_rst_d;
    logic               pll_ready_q, pll_ready_d;
    logic               lock_lost_q, lock_lost_d;
    logic               retry_inc;

    // NOTE: every signal written here gets a default before the case so that
    // no path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        retry_inc   = 1'b0;
        lock_lost_d = 1'b0;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == PLLRST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Lock takes priority over a timeout expiring on the same edge.
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                // A glitch is not a retry: go back to waiting with a fresh timeout.
                if (!lock_s)                   state_d = S_WAIT;
                else if (cnt_q == STABLE_LAST) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d     = S_PLLRST;
                    retry_inc   = 1'b1;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase

        // Shared timer: cleared on any state change, idle in S_RUN where
        // nothing is timed, so it never wraps.
        if (state_d != state_q)  cnt_d = '0;
        else if (state_q == S_RUN) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CNT_W'(1);

        retry_d = (retry_inc && (retry_q != '1)) ? retry_q + RETRY_W'(1) : retry_q;

        pll_rst_d   = (state_d == S_PLLRST);
        sys_rst_d   = (state_d != S_RUN);
        pll_ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            pll_ready_q <= pll_ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign pll_ready   = pll_ready_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;

endmodule
